// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: funct3 codes,
// FSM states and the ALU control codes the core's ALU decodes.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_FIX, S_DONE} state_t;

  function automatic logic signed_rs1(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic signed_rs2(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Core <-> sequencer bundle: launch/operands, borrowed ALU port and result.
interface muldiv_sequencer_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic [31:0] alu_sum;
  logic        alu_req;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, funct3, rs1, rs2, kill, alu_sum,
                  input  alu_req, alu_a, alu_b, alu_ctrl, busy, done, result);
  modport slave  (input  start, funct3, rs1, rs2, kill, alu_sum,
                  output alu_req, alu_a, alu_b, alu_ctrl, busy, done, result);
endinterface

// File: rtl/muldiv_sequencer_cond_negate.sv
// Conditional two's-complement negation, used for sign handling outside the ALU.
module cond_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  assign dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;
endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: 32 shift-add / restoring-divide steps driven
// through the core's shared ALU adder, with local sign conversion.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  muldiv_sequencer_if.slave bus
);

  state_t      state;
  logic [2:0]  f3;
  logic [31:0] op_a, op_b, hi, lo;
  logic [5:0]  cnt;

  logic        sa, sb, is_mul, is_rem, carry, no_borrow, fix_neg;
  logic [31:0] mag_a, mag_b, hi_n, lo_n, fix_res;
  logic [63:0] fix_in, fix_out;

  assign is_mul = ~f3[2];
  assign is_rem = (f3 == F3_REM) || (f3 == F3_REMU);
  assign sa     = op_a[31] & signed_rs1(f3);
  assign sb     = op_b[31] & signed_rs2(f3);

  cond_negate #(.W(32)) u_mag_a (.neg(sa), .din(op_a), .dout(mag_a));
  cond_negate #(.W(32)) u_mag_b (.neg(sb), .din(op_b), .dout(mag_b));

  // Remainder rides in the low half so a 64-bit negate also serves 32-bit fixes.
  assign fix_in  = is_rem ? {lo, hi} : {hi, lo};
  assign fix_neg = is_rem ? sa : (sa ^ sb);
  cond_negate #(.W(64)) u_fix (.neg(fix_neg), .din(fix_in), .dout(fix_out));

  always_comb begin
    carry     = (bus.alu_a[31] & bus.alu_b[31]) |
                ((bus.alu_a[31] | bus.alu_b[31]) & ~bus.alu_sum[31]);
    no_borrow = (bus.alu_a[31] & ~bus.alu_b[31]) |
                (~(bus.alu_a[31] ^ bus.alu_b[31]) & ~bus.alu_sum[31]);
    hi_n = hi;
    lo_n = lo;
    if (is_mul) begin
      if (lo[0]) {hi_n, lo_n} = {carry, bus.alu_sum, lo[31:1]};
      else       {hi_n, lo_n} = {1'b0, hi, lo[31:1]};
    end else if (hi[31] | no_borrow) begin
      hi_n = bus.alu_sum;
      lo_n = {lo[30:0], 1'b1};
    end else begin
      hi_n = bus.alu_a;
      lo_n = {lo[30:0], 1'b0};
    end
    case (f3)
      F3_MUL:                      fix_res = fix_out[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = fix_out[63:32];
      default:                     fix_res = fix_out[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      f3           <= F3_MUL;
      op_a         <= '0;
      op_b         <= '0;
      hi           <= '0;
      lo           <= '0;
      cnt          <= '0;
      bus.alu_req  <= 1'b0;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_ctrl <= ALU_ADD;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
    end else if (state != S_IDLE && bus.kill) begin
      state        <= S_IDLE;
      bus.alu_req  <= 1'b0;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_ctrl <= ALU_ADD;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          state    <= S_SETUP;
          f3       <= bus.funct3;
          op_a     <= bus.rs1;
          op_b     <= bus.rs2;
          cnt      <= '0;
          bus.busy <= 1'b1;
        end
        S_SETUP: begin
          if (!is_mul && op_b == 32'd0) begin
            state      <= S_DONE;
            bus.done   <= 1'b1;
            bus.result <= is_rem ? op_a : 32'hFFFF_FFFF;
          end else if ((f3 == F3_DIV || f3 == F3_REM) &&
                       op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
            state      <= S_DONE;
            bus.done   <= 1'b1;
            bus.result <= is_rem ? 32'd0 : 32'h8000_0000;
          end else begin
            state        <= S_RUN;
            hi           <= '0;
            lo           <= mag_a;
            bus.alu_req  <= 1'b1;
            bus.alu_a    <= is_mul ? 32'd0 : {31'd0, mag_a[31]};
            bus.alu_b    <= mag_b;
            bus.alu_ctrl <= is_mul ? ALU_ADD : ALU_SUB;
          end
        end
        S_RUN: begin
          hi <= hi_n;
          lo <= lo_n;
          // Next step's operand is prepared now so the ALU sees it registered.
          bus.alu_a <= is_mul ? hi_n : {hi_n[30:0], lo[30]};
          if (cnt == 6'd31) begin
            state        <= S_FIX;
            bus.alu_req  <= 1'b0;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_ctrl <= ALU_ADD;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_FIX: begin
          state      <= S_DONE;
          bus.done   <= 1'b1;
          bus.result <= fix_res;
        end
        default: begin
          state    <= S_IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
